// File: rtl/sc_phase_gen.sv
// Non-overlapping two-phase clock generator for the switched-capacitor filter array.
// Each period runs P1 -> G12 -> P2 -> G21. Every phase output is registered. The
// configuration is captured once per period, on entry to P1.
`timescale 1ns / 1ps
module sc_phase_gen #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [CNT_W-1:0]   cfg_p1_len,
    input  logic [CNT_W-1:0]   cfg_p2_len,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic [CNT_W-1:0]   cfg_adv,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [NUM_CH-1:0]  ch_en,
    output logic [NUM_CH-1:0]  phi1,
    output logic [NUM_CH-1:0]  phi2,
    output logic [NUM_CH-1:0]  phi1e,
    output logic [NUM_CH-1:0]  phi2e,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] period_cnt
);

    typedef enum logic [2:0] {StIdle, StP1, StG12, StP2, StG21} state_e;

    localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BurstOne = BURST_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   p1_q, p1_d, p2_q, p2_d, gap_q, gap_d, adv1_q, adv1_d, adv2_q, adv2_d;
    logic [BURST_W-1:0] burst_q, burst_d, period_q, period_d;
    logic               mode_q, mode_d, pend_q, pend_d, done_q, done_d, busy_q, busy_d;
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  phi1_q, phi1_d, phi2_q, phi2_d, phi1e_q, phi1e_d, phi2e_q, phi2e_d;

    // Effective values of the live config inputs: zero lengths become 1, and the advance
    // is clamped so that an early phase stays high for at least one clock.
    logic [CNT_W-1:0]   in_p1, in_p2, in_gap, in_adv1, in_adv2;
    logic [BURST_W-1:0] in_burst;
    logic [BURST_W:0]   period_ext;
    logic               burst_end, enter_p1;

    // Compute the effective config values and the burst-completion test.
    always_comb begin
        in_p1      = (cfg_p1_len == '0) ? CntOne : cfg_p1_len;
        in_p2      = (cfg_p2_len == '0) ? CntOne : cfg_p2_len;
        in_gap     = (cfg_gap == '0) ? CntOne : cfg_gap;
        in_burst   = (cfg_burst == '0) ? BurstOne : cfg_burst;
        in_adv1    = (cfg_adv > in_p1 - CntOne) ? in_p1 - CntOne : cfg_adv;
        in_adv2    = (cfg_adv > in_p2 - CntOne) ? in_p2 - CntOne : cfg_adv;
        // One extra bit, so the compare still works when the count is saturated.
        period_ext = {1'b0, period_q} + {{BURST_W{1'b0}}, 1'b1};
        burst_end  = mode_q && (period_ext >= {1'b0, burst_q});
    end

    // Next-state logic: sequence the phases, reload the counter and capture the snapshot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        gap_d    = gap_q;
        adv1_d   = adv1_q;
        adv2_d   = adv2_q;
        burst_d  = burst_q;
        mode_d   = mode_q;
        en_d     = en_q;
        pend_d   = pend_q;
        period_d = period_q;
        done_d   = 1'b0;
        enter_p1 = 1'b0;

        if (state_q != StIdle && stop) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    enter_p1 = 1'b1;
                    period_d = '0;
                end
            end
            StP1: begin
                if (cnt_q == '0) begin
                    state_d = StG12;
                    cnt_d   = gap_q - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StG12: begin
                if (cnt_q == '0) begin
                    state_d = StP2;
                    cnt_d   = p2_q - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StP2: begin
                if (cnt_q == '0) begin
                    state_d = StG21;
                    cnt_d   = gap_q - CntOne;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StG21: begin
                if (cnt_q == '0) begin
                    period_d = (&period_q) ? period_q : period_ext[BURST_W-1:0];
                    if (pend_d || burst_end) begin
                        // A pending stop and the end of a burst collapse into one done pulse.
                        state_d = StIdle;
                        pend_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        enter_p1 = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_p1) begin
            state_d = StP1;
            cnt_d   = in_p1 - CntOne;
            p1_d    = in_p1;
            p2_d    = in_p2;
            gap_d   = in_gap;
            adv1_d  = in_adv1;
            adv2_d  = in_adv2;
            burst_d = in_burst;
            mode_d  = mode;
            en_d    = ch_en;
        end
    end

    // Decode the outputs from the next state so that they can be registered.
    // An early phase is high while the remaining count is at least the advance.
    always_comb begin
        busy_d  = (state_d != StIdle);
        phi1_d  = (state_d == StP1) ? en_d : '0;
        phi2_d  = (state_d == StP2) ? en_d : '0;
        phi1e_d = (state_d == StP1 && cnt_d >= adv1_d) ? en_d : '0;
        phi2e_d = (state_d == StP2 && cnt_d >= adv2_d) ? en_d : '0;
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p1_q     <= CntOne;
            p2_q     <= CntOne;
            gap_q    <= CntOne;
            adv1_q   <= '0;
            adv2_q   <= '0;
            burst_q  <= BurstOne;
            mode_q   <= 1'b0;
            en_q     <= '0;
            pend_q   <= 1'b0;
            period_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            phi1_q   <= '0;
            phi2_q   <= '0;
            phi1e_q  <= '0;
            phi2e_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            gap_q    <= gap_d;
            adv1_q   <= adv1_d;
            adv2_q   <= adv2_d;
            burst_q  <= burst_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            period_q <= period_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            phi1_q   <= phi1_d;
            phi2_q   <= phi2_d;
            phi1e_q  <= phi1e_d;
            phi2e_q  <= phi2e_d;
        end
    end

    assign phi1       = phi1_q;
    assign phi2       = phi2_q;
    assign phi1e      = phi1e_q;
    assign phi2e      = phi2e_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign period_cnt = period_q;

endmodule

// File: tb/tb_sc_phase_gen.sv
// Bench for sc_phase_gen. A per-period reference model pushes the expected output vector
// for every cycle into a queue. A monitor pops one entry on each falling edge and compares.
`timescale 1ns / 1ps
module tb_sc_phase_gen;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int BW  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           mode = 1'b0;
    logic [CW-1:0]  cfg_p1_len = '0, cfg_p2_len = '0, cfg_gap = '0, cfg_adv = '0;
    logic [BW-1:0]  cfg_burst = '0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] phi1, phi2, phi1e, phi2e;
    logic           busy, done;
    logic [BW-1:0]  period_cnt;
    logic [33:0]    all_out;

    sc_phase_gen #(.NUM_CH(NCH), .CNT_W(CW), .BURST_W(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .cfg_p1_len (cfg_p1_len),
        .cfg_p2_len (cfg_p2_len),
        .cfg_gap    (cfg_gap),
        .cfg_adv    (cfg_adv),
        .cfg_burst  (cfg_burst),
        .ch_en      (ch_en),
        .phi1       (phi1),
        .phi2       (phi2),
        .phi1e      (phi1e),
        .phi2e      (phi2e),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    assign all_out = {phi1, phi2, phi1e, phi2e, busy, done, period_cnt};

    typedef struct packed {
        logic [NCH-1:0] phi1;
        logic [NCH-1:0] phi2;
        logic [NCH-1:0] phi1e;
        logic [NCH-1:0] phi2e;
        logic           busy;
        logic           done;
        logic [BW-1:0]  pcnt;
    } vec_t;

    vec_t exp_q[$];
    vec_t mon_act, mon_exp;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_on = 1'b0;

    // Reference model state, tracked one period at a time.
    bit   m_busy = 1'b0, m_pend = 1'b0, m_mode = 1'b0;
    int   m_left = 0, m_burst = 1, m_cnt = 0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic push_idle(input bit d);
        vec_t v;
        v      = '0;
        v.done = d;
        v.pcnt = BW'(m_cnt);
        exp_q.push_back(v);
    endtask

    // Push the whole expected waveform of one period, using the config sampled at this edge.
    task automatic push_period();
        int p1, p2, g, a1, a2;
        vec_t v;
        p1 = eff(int'(cfg_p1_len));
        p2 = eff(int'(cfg_p2_len));
        g  = eff(int'(cfg_gap));
        a1 = min2(int'(cfg_adv), p1 - 1);
        a2 = min2(int'(cfg_adv), p2 - 1);
        for (int i = 0; i < p1 + p2 + 2 * g; i++) begin
            v      = '0;
            v.busy = 1'b1;
            v.pcnt = BW'(m_cnt);
            if (i < p1) begin
                v.phi1  = ch_en;
                v.phi1e = (i < p1 - a1) ? ch_en : '0;
            end else if (i >= p1 + g && i < p1 + g + p2) begin
                v.phi2  = ch_en;
                v.phi2e = (i - p1 - g < p2 - a2) ? ch_en : '0;
            end
            exp_q.push_back(v);
        end
        m_left  = p1 + p2 + 2 * g;
        m_mode  = mode;
        m_burst = eff(int'(cfg_burst));
    endtask

    // Model: once per rising edge, decide what the DUT must show in the following cycle(s).
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            mon_on = 1'b0;
            m_busy = 1'b0;
            m_pend = 1'b0;
            m_cnt  = 0;
            m_left = 0;
        end else begin
            mon_on = 1'b1;
            if (!m_busy) begin
                if (start) begin
                    m_cnt  = 0;
                    m_pend = 1'b0;
                    m_busy = 1'b1;
                    push_period();
                end else begin
                    push_idle(1'b0);
                end
            end else begin
                if (stop) m_pend = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_pend || (m_mode && m_cnt >= m_burst)) begin
                        m_busy = 1'b0;
                        m_pend = 1'b0;
                        push_idle(1'b1);
                    end else begin
                        push_period();
                    end
                end
            end
        end
    end

    // Monitor: on each falling edge, compare the DUT outputs against the next queued vector.
    initial forever begin
        @(negedge clk);
        if (rst_n && mon_on) begin
            mon_act = '{phi1, phi2, phi1e, phi2e, busy, done, period_cnt};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty t=%0t actual=%h required=<entry>", $time, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL cycle t=%0t actual=%h required=%h", $time, mon_act, mon_exp);
                end
            end
            n_vec++;
            if ((phi1 & phi2) != '0 || (phi1e & ~phi1) != '0 || (phi2e & ~phi2) != '0) begin
                n_err++;
                $display("FAIL phase_rules t=%0t phi1=%b phi2=%b phi1e=%b phi2e=%b required=disjoint",
                         $time, phi1, phi2, phi1e, phi2e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic set_cfg(input int p1, input int p2, input int g, input int a, input int b,
                           input bit m, input int en);
        cfg_p1_len = CW'(p1);
        cfg_p2_len = CW'(p2);
        cfg_gap    = CW'(g);
        cfg_adv    = CW'(a);
        cfg_burst  = BW'(b);
        mode       = m;
        ch_en      = NCH'(en);
    endtask

    task automatic rand_cfg();
        cfg_p1_len = CW'($urandom_range(0, 5));
        cfg_p2_len = CW'($urandom_range(0, 5));
        cfg_gap    = CW'($urandom_range(0, 3));
        cfg_adv    = CW'($urandom_range(0, 7));
        cfg_burst  = BW'($urandom_range(0, 3));
        ch_en      = NCH'($urandom_range(0, 15));
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int stop_at;
        // Hold reset while toggling the inputs; every output must stay at zero.
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b1;
            stop  = (i % 2) == 1;
            rand_cfg();
            chk("reset_hold", 64'(all_out), 64'd0);
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();
        rst_n = 1'b1;

        // Continuous 3/3/1, with stop requested in P2 of the second period.
        set_cfg(3, 3, 1, 0, 0, 1'b0, 15);
        pulse_start();
        repeat (13) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(40);
        chk("stop_done", 64'(done), 64'd1);
        chk("stop_pcnt", 64'(period_cnt), 64'd2);

        // Early phase advance, both unclamped and clamped.
        set_cfg(4, 4, 1, 2, 1, 1'b1, 15);
        pulse_start();
        wait_idle(40);
        set_cfg(4, 2, 1, 9, 1, 1'b1, 10);
        pulse_start();
        wait_idle(40);

        // Bursts of 3 periods and of 0 (treated as 1).
        set_cfg(2, 2, 2, 0, 3, 1'b1, 15);
        pulse_start();
        wait_idle(60);
        chk("burst3_pcnt", 64'(period_cnt), 64'd3);
        chk("burst3_done", 64'(done), 64'd1);
        tick();
        chk("burst3_done_once", 64'(done), 64'd0);
        set_cfg(2, 2, 2, 0, 0, 1'b1, 15);
        pulse_start();
        wait_idle(30);
        chk("burst0_pcnt", 64'(period_cnt), 64'd1);

        // Change config and channel enables during P2; takes effect from the next period.
        set_cfg(3, 3, 1, 1, 0, 1'b0, 15);
        pulse_start();
        repeat (5) tick();
        cfg_p1_len = 8'd5;
        ch_en      = 4'b0101;
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(40);

        // All-zero config: a 4-clock period (1,1,1,1).
        set_cfg(0, 0, 0, 0, 2, 1'b1, 15);
        pulse_start();
        wait_idle(20);
        chk("zero_pcnt", 64'(period_cnt), 64'd2);

        // Random runs: config churns mid-run, extra starts while busy, stop at random points.
        for (int r = 0; r < 25; r++) begin
            rand_cfg();
            mode = 1'($urandom_range(0, 1));
            pulse_start();
            stop_at = $urandom_range(3, 60);
            for (int c = 0; c < 300 && busy; c++) begin
                if ($urandom_range(0, 3) == 0) rand_cfg();
                start = ($urandom_range(0, 19) == 0);
                stop  = (c >= stop_at) || ($urandom_range(0, 39) == 0);
                tick();
            end
            start = 1'b0;
            stop  = 1'b0;
            wait_idle(200);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Asynchronous reset in the middle of P1 clears the outputs immediately.
        set_cfg(10, 3, 1, 0, 0, 1'b0, 15);
        pulse_start();
        repeat (3) tick();
        chk("mid_p1_phi1", 64'(phi1), 64'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'(all_out), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_reset_idle", 64'(all_out), 64'd0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sc_phase_gen.md
# sc_phase_gen

Programmable non-overlapping two-phase clock generator driving the phi1/phi2 switches of the switched-capacitor filter array. It generalises the fixed two-phase scheme to NUM_CH filter channels, adds programmable phase widths, gap and bottom-plate early-phase advance, and supports continuous and counted-burst modes. Sits between the digital control block and the SC filter switch drivers; all phase outputs are registered and glitch-free.

## Interface
- NUM_CH, 4, number of SC filter channels (independent phase-output sets)
- CNT_W, 8, width of all timing config fields and counters
- BURST_W, 16, width of burst period count
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins operation from IDLE, ignored otherwise
- stop  in  1  request to halt after the current period completes
- mode  in  1  0 = continuous, 1 = burst
- cfg_p1_len  in  CNT_W  phi1 high width in clocks (0 treated as 1)
- cfg_p2_len  in  CNT_W  phi2 high width in clocks (0 treated as 1)
- cfg_gap  in  CNT_W  non-overlap gap in clocks (0 treated as 1)
- cfg_adv  in  CNT_W  early-phase advance in clocks, clamped to phase width − 1
- cfg_burst  in  BURST_W  periods per burst (0 treated as 1)
- ch_en  in  NUM_CH  per-channel enable
- phi1, phi2  out  NUM_CH  main phases per channel
- phi1e, phi2e  out  NUM_CH  early (bottom-plate) phases per channel
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on burst completion or stop completion
- period_cnt  out  BURST_W  completed periods since start, saturating

## Operation
- States: IDLE, P1, G12, P2, G21. Down-counter reloaded on every state entry.
- IDLE --start--> P1 (P1 −p1_len→ G12 −gap→ P2 −p2_len→ G21 −gap→ P1 or IDLE).
- Config snapshot: cfg_*, mode, ch_en registered on each entry to P1; changes mid-period have no effect until the next period.
- phi1 high throughout P1; phi2 high throughout P2; both low in G12, G21, IDLE. phi1 and phi2 never high in the same cycle.
- phi1e rises with phi1 and falls eff_adv clocks before phi1 falls; eff_adv = min(cfg_adv, p1_len − 1). Same for phi2e with p2_len. cfg_adv = 0 → early phases identical to main phases.
- Channel gating: output bit i is driven only if snapshot ch_en[i] = 1; disabled channels hold all four phases low for the whole period.
- period_cnt increments on leaving G21; cleared on start; saturates at all ones.
- Burst mode: after G21 of period cfg_burst → IDLE, done pulses.
- Continuous mode: loops until stop.
- stop: latched as pending in any non-IDLE state; honoured only at end of G21 (never truncates a phase) → IDLE, done pulses. stop in IDLE ignored. start while busy ignored.
- Burst end and pending stop coinciding: single done pulse.
- Reset (async, any time): state IDLE, all phases, busy, done 0, period_cnt 0, pending stop cleared.

## Timing
- start sampled high at edge t0: phi1 high and busy high from t0 (registered, visible in cycle after t0).
- Period = p1_len + p2_len + 2·gap clocks; no idle cycles between consecutive periods.
- done asserted for exactly the cycle after the final G21 exit edge; busy low the same cycle.
- All outputs are flop outputs; no combinational path from inputs to phase outputs.

## Test plan
- Reset values: hold rst_n low, toggle inputs → all outputs 0; deassert mid-P1 re-assert → phi1 drops asynchronously.
- Continuous, p1=3, p2=3, gap=1, adv=0, ch_en=4'b1111: start → phi1 high 3 clk, low 1, phi2 high 3, low 1, period 8; stop mid-P2 → finishes G21, done one cycle, busy low.
- Early phase: p1=4, adv=2 → phi1e high 2 clk, phi1 high 4 clk, both rise together; adv=9 → clamped, phi1e high 1 clk.
- Burst: mode=1, cfg_burst=3, p1=p2=2, gap=2 → exactly 3 periods (24 clk), period_cnt=3, single done pulse; cfg_burst=0 → 1 period.
- Config/channel change mid-period: change p1_len and ch_en=4'b0101 during P2 → current period unchanged, next period uses new values, channels 1,3 all low.
- Zero-clamp and overlap check: all cfg=0 → period 4 (1,1,1,1); assertion over all runs: phi1[i]&phi2[i] never 1, phi1e ⊆ phi1.
